// File: rtl/control_x.sv
// Execute-stage control-flow resolver.
// Decodes the instruction in X, resolves branches from the comparator flags and drives the
// fetch redirect (x_ctrl/kill_fd). A shadow FSM masks wrong-path instructions that reach X
// after a redirect, and a wrapping counter records how many redirects have issued.
module control_x #(
  parameter int unsigned SHADOW_CYCLES = 1,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_x,
  input  logic             valid_x,
  input  logic             stall,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  output logic             x_ctrl,
  output logic             kill_fd,
  output logic             kill_x,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  // Shadow length is at most 3, so a 2-bit down-counter is enough.
  localparam logic [1:0] ShadowInit = 2'(SHADOW_CYCLES);

  typedef enum logic [0:0] {StIdle, StShadow} state_e;

  state_e     state;
  logic [1:0] shadow_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_branch;
  logic       is_jump;
  logic       cond;
  logic       live;
  logic       take;

  assign opcode    = inst_x[6:0];
  assign funct3    = inst_x[14:12];
  assign is_branch = (opcode == OpBranch);
  assign is_jump   = (opcode == OpJal) || (opcode == OpJalr);

  // Branch condition selected by funct3; reserved encodings never take.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = br_eq;
      3'b001:  cond = !br_eq;
      3'b100:  cond = br_lt;
      3'b101:  cond = !br_lt;
      3'b110:  cond = br_ltu;
      3'b111:  cond = !br_ltu;
      default: cond = 1'b0;
    endcase
  end

  // Redirect and kill outputs are Mealy so fetch turns around in the resolving cycle.
  always_comb begin
    live    = valid_x && (state == StIdle);
    take    = live && (is_jump || (is_branch && cond));
    x_ctrl  = take && !stall && !rst;
    kill_fd = x_ctrl;
    kill_x  = valid_x && (state == StShadow) && !rst;
  end

  // Shadow FSM: opens on a redirect, counts down on non-stalled cycles, holds on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      shadow_cnt <= 2'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (x_ctrl) begin
            state      <= StShadow;
            shadow_cnt <= ShadowInit;
          end
        end
        StShadow: begin
          if (!stall) begin
            shadow_cnt <= shadow_cnt - 2'd1;
            if (shadow_cnt <= 2'd1) begin
              state <= StIdle;
            end
          end
        end
        default: begin
          state      <= StIdle;
          shadow_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Redirect counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt <= '0;
    end else if (x_ctrl) begin
      redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_control_x.sv
// Directed bench for control_x: reset, branch decode, shadow masking, stall, reset
// mid-shadow and counter wrap, across three parameterisations sharing one stimulus.
module tb_control_x;

  localparam logic [31:0] IJal  = 32'h0000006F;
  localparam logic [31:0] IJalr = 32'h00000067;
  localparam logic [31:0] IBeq  = 32'h00000063;
  localparam logic [31:0] IBne  = 32'h00001063;
  localparam logic [31:0] IF010 = 32'h00002063;
  localparam logic [31:0] IBlt  = 32'h00004063;
  localparam logic [31:0] IBge  = 32'h00005063;
  localparam logic [31:0] IBgeu = 32'h00007063;
  localparam logic [31:0] IAddi = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_x;
  logic        valid_x, stall, br_eq, br_lt, br_ltu;

  logic        x_ctrl1, kill_fd1, kill_x1;
  logic [15:0] cnt1;
  logic        x_ctrl3, kill_fd3, kill_x3;
  logic [15:0] cnt3;
  logic        x_ctrlw, kill_fdw, kill_xw;
  logic [3:0]  cntw;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  control_x #(.SHADOW_CYCLES(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .inst_x(inst_x), .valid_x(valid_x), .stall(stall),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .x_ctrl(x_ctrl1), .kill_fd(kill_fd1), .kill_x(kill_x1), .redirect_cnt(cnt1)
  );

  control_x #(.SHADOW_CYCLES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .inst_x(inst_x), .valid_x(valid_x), .stall(stall),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .x_ctrl(x_ctrl3), .kill_fd(kill_fd3), .kill_x(kill_x3), .redirect_cnt(cnt3)
  );

  control_x #(.SHADOW_CYCLES(1), .CNT_W(4)) dutw (
    .clk(clk), .rst(rst), .inst_x(inst_x), .valid_x(valid_x), .stall(stall),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .x_ctrl(x_ctrlw), .kill_fd(kill_fdw), .kill_x(kill_xw), .redirect_cnt(cntw)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] i, input logic v, input logic eq, input logic lt,
                        input logic ltu);
    inst_x  = i;
    valid_x = v;
    br_eq   = eq;
    br_lt   = lt;
    br_ltu  = ltu;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_x = 1'b0;
    stall   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles with a live JAL in X.
    tick();
    chk1("rst1_x_ctrl", x_ctrl1, 1'b0);
    chk1("rst1_kill_fd", kill_fd1, 1'b0);
    chk1("rst1_kill_x", kill_x1, 1'b0);
    chk16("rst1_cnt", cnt1, 16'd0);
    tick();
    chk1("rst2_x_ctrl", x_ctrl1, 1'b0);
    chk16("rst2_cnt", cnt1, 16'd0);
    rst = 1'b0;
    #1;
    chk1("post_rst_x_ctrl", x_ctrl1, 1'b1);
    chk1("post_rst_kill_fd", kill_fd1, 1'b1);
    tick();
    chk1("post_rst_shadow_kill_x", kill_x1, 1'b1);
    chk1("post_rst_shadow_x_ctrl", x_ctrl1, 1'b0);
    chk16("post_rst_cnt", cnt1, 16'd1);
    valid_x = 1'b0;

    // Branch matrix, sampled combinationally; valid dropped before the edge.
    do_reset();
    set_in(IBeq, 1'b1, 1'b1, 1'b0, 1'b0);  #1; chk1("beq_eq1", x_ctrl1, 1'b1);
    set_in(IBne, 1'b1, 1'b1, 1'b0, 1'b0);  #1; chk1("bne_eq1", x_ctrl1, 1'b0);
    set_in(IBgeu, 1'b1, 1'b0, 1'b1, 1'b0); #1; chk1("bgeu_ltu0", x_ctrl1, 1'b1);
    set_in(IF010, 1'b1, 1'b1, 1'b1, 1'b1); #1; chk1("f3_010", x_ctrl1, 1'b0);
    set_in(IAddi, 1'b1, 1'b1, 1'b1, 1'b1); #1; chk1("addi", x_ctrl1, 1'b0);
    set_in(IJal, 1'b0, 1'b1, 1'b1, 1'b1);  #1; chk1("jal_invalid", x_ctrl1, 1'b0);
    set_in(IBge, 1'b1, 1'b0, 1'b1, 1'b0);  #1; chk1("bge_lt1", x_ctrl1, 1'b0);
    set_in(IJalr, 1'b1, 1'b0, 1'b1, 1'b1); #1; chk1("jalr_flags", x_ctrl1, 1'b1);
    valid_x = 1'b0;
    tick();
    chk16("matrix_no_count", cnt1, 16'd0);

    // Shadow with SHADOW_CYCLES=1: wrong-path JALR is masked, next taken BEQ redirects.
    set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk1("sh_jal_x_ctrl", x_ctrl1, 1'b1);
    tick();
    set_in(IJalr, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk1("sh_jalr_x_ctrl", x_ctrl1, 1'b0);
    chk1("sh_jalr_kill_x", kill_x1, 1'b1);
    chk16("sh_cnt1", cnt1, 16'd1);
    tick();
    set_in(IBeq, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    chk1("sh_beq_x_ctrl", x_ctrl1, 1'b1);
    chk1("sh_beq_kill_x", kill_x1, 1'b0);
    tick();
    chk16("sh_cnt2", cnt1, 16'd2);
    valid_x = 1'b0;
    tick();

    // Stall holds a taken BLT for 3 cycles; it redirects once on release.
    do_reset();
    set_in(IBlt, 1'b1, 1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("stall_x_ctrl", x_ctrl1, 1'b0);
      tick();
    end
    chk16("stall_cnt0", cnt1, 16'd0);
    stall = 1'b0;
    #1;
    chk1("unstall_x_ctrl", x_ctrl1, 1'b1);
    tick();
    chk16("unstall_cnt1", cnt1, 16'd1);
    // Stall during the shadow extends kill_x.
    set_in(IAddi, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    #1; chk1("sh_stall_kill_x_a", kill_x1, 1'b1);
    tick(); chk1("sh_stall_kill_x_b", kill_x1, 1'b1);
    tick(); chk1("sh_stall_kill_x_c", kill_x1, 1'b1);
    stall = 1'b0;
    #1; chk1("sh_unstall_kill_x", kill_x1, 1'b1);
    tick(); chk1("sh_done_kill_x", kill_x1, 1'b0);
    chk16("sh_stall_cnt", cnt1, 16'd1);
    valid_x = 1'b0;

    // SHADOW_CYCLES=3: full window length, then reset mid-shadow.
    do_reset();
    set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk1("s3_jal_x_ctrl", x_ctrl3, 1'b1);
    tick();
    set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("s3_window_kill_x", kill_x3, 1'b1);
      chk1("s3_window_x_ctrl", x_ctrl3, 1'b0);
      tick();
    end
    chk1("s3_after_kill_x", kill_x3, 1'b0);
    chk1("s3_after_x_ctrl", x_ctrl3, 1'b1);
    tick();
    set_in(IAddi, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk1("s3_mid_kill_x", kill_x3, 1'b1);
    tick();
    rst = 1'b1; #1;
    chk1("s3_rst_kill_x_comb", kill_x3, 1'b0);
    tick();
    chk16("s3_rst_cnt", cnt3, 16'd0);
    chk1("s3_rst_kill_x", kill_x3, 1'b0);
    rst = 1'b0;
    set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk1("s3_post_rst_x_ctrl", x_ctrl3, 1'b1);
    chk1("s3_post_rst_kill_x", kill_x3, 1'b0);
    tick();
    chk16("s3_post_rst_cnt", cnt3, 16'd1);
    valid_x = 1'b0;

    // CNT_W=4 wraps back to 0 after 16 redirects.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(IJal, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      valid_x = 1'b0;
      if (i == 14) chk16("wrap_cnt15", 16'(cntw), 16'd15);
      tick();
    end
    chk16("wrap_cnt0", 16'(cntw), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
